// File: rtl/cnt_pkg.sv
// Shared encodings for the down-count timer: FSM state and run mode.
package cnt_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic {MODE_ONESHOT = 1'b0, MODE_RELOAD = 1'b1} mode_t;
endpackage

// File: rtl/down_cnt_reg.sv
// Falling-edge counter register with load, decrement and zero detect.
module down_cnt_reg
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_count;

  always_ff @(negedge clk) begin
    if (!reset)      r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_dec)  r_count <= r_count - WIDTH'(1);
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer: one-shot or auto-reload, with hold, stop and a done pulse.
module down_count_timer
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             hold,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  state_t           r_state, w_nxt_state;
  mode_t            r_mode;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  logic             w_load, w_dec, w_capture, w_nxt_done, w_zero;
  logic [WIDTH-1:0] w_load_val;

  down_cnt_reg #(.WIDTH(WIDTH)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_count    (count),
    .o_zero     (w_zero)
  );

  always_ff @(negedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_ONESHOT;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_done  <= w_nxt_done;
      if (w_capture) begin
        r_reload <= load_val;
        r_mode   <= mode_t'(mode);
      end
    end
  end

  // RUN priority: stop > start (restart) > hold > terminal count > decrement.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_done  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = load_val;
    w_dec       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_capture   = 1'b1;
          w_nxt_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
        end else if (start) begin
          w_load    = 1'b1;
          w_capture = 1'b1;
        end else if (hold) begin
          w_nxt_state = ST_RUN;
        end else if (w_zero) begin
          w_nxt_done = 1'b1;
          if (r_mode == MODE_RELOAD) begin
            w_load     = 1'b1;
            w_load_val = r_reload;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
endmodule

// File: tb/tb_down_count_timer.sv
// Directed vector bench for down_count_timer (WIDTH=4, falling-edge design).
module tb_down_count_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, mode, hold, stop;
  logic [W-1:0] load_val, count;
  logic         busy, done;

  always #5 clk = ~clk;

  down_count_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val), .mode(mode),
    .hold(hold), .stop(stop), .count(count), .busy(busy), .done(done)
  );

  typedef struct {
    logic         rst, st;
    logic [W-1:0] lv;
    logic         m, h, sp;
    logic [W-1:0] ec;
    logic         eb, ed;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void v(input logic rst, input logic st, input logic [W-1:0] lv,
                            input logic m, input logic h, input logic sp,
                            input logic [W-1:0] ec, input logic eb, input logic ed);
    vec_t x;
    x.rst = rst; x.st = st; x.lv = lv; x.m = m; x.h = h; x.sp = sp;
    x.ec = ec; x.eb = eb; x.ed = ed;
    vecs.push_back(x);
  endfunction

  task automatic drive(input logic rst, input logic st, input logic [W-1:0] lv,
                       input logic m, input logic h, input logic sp);
    reset = rst; start = st; load_val = lv; mode = m; hold = h; stop = sp;
  endtask

  // Active edge is negedge; sample 1 time unit later.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);

    // reset dominates start
    v(0,1,9,0,0,0, 0,0,0);
    v(0,1,9,0,0,0, 0,0,0);
    // one-shot, N=3: done on 4th edge after load
    v(1,1,3,0,0,0, 3,1,0);
    v(1,0,0,0,0,0, 2,1,0);
    v(1,0,0,0,0,0, 1,1,0);
    v(1,0,0,0,0,0, 0,1,0);
    v(1,0,0,0,0,0, 0,0,1);
    v(1,0,0,0,0,0, 0,0,0);
    // auto-reload, N=2: period 3
    v(1,1,2,1,0,0, 2,1,0);
    v(1,0,0,0,0,0, 1,1,0);
    v(1,0,0,0,0,0, 0,1,0);
    v(1,0,0,0,0,0, 2,1,1);
    v(1,0,0,0,0,0, 1,1,0);
    v(1,0,0,0,0,0, 0,1,0);
    v(1,0,0,0,0,0, 2,1,1);
    v(1,0,0,0,0,0, 1,1,0);
    v(1,0,0,0,0,1, 1,0,0);
    // hold for 3 edges at count 5; done at 9+3 edges
    v(1,1,8,0,0,0, 8,1,0);
    v(1,0,0,0,0,0, 7,1,0);
    v(1,0,0,0,0,0, 6,1,0);
    v(1,0,0,0,0,0, 5,1,0);
    v(1,0,0,0,1,0, 5,1,0);
    v(1,0,0,0,1,0, 5,1,0);
    v(1,0,0,0,1,0, 5,1,0);
    v(1,0,0,0,0,0, 4,1,0);
    v(1,0,0,0,0,0, 3,1,0);
    v(1,0,0,0,0,0, 2,1,0);
    v(1,0,0,0,0,0, 1,1,0);
    v(1,0,0,0,0,0, 0,1,0);
    v(1,0,0,0,0,0, 0,0,1);
    // stop at count 7; hold/stop ignored in IDLE
    v(1,1,10,0,0,0, 10,1,0);
    v(1,0,0,0,0,0, 9,1,0);
    v(1,0,0,0,0,0, 8,1,0);
    v(1,0,0,0,0,0, 7,1,0);
    v(1,0,0,0,0,1, 7,0,0);
    v(1,0,0,0,1,1, 7,0,0);
    // restart in RUN recaptures value and mode
    v(1,1,5,0,0,0, 5,1,0);
    v(1,0,0,0,0,0, 4,1,0);
    v(1,1,1,1,0,0, 1,1,0);
    v(1,0,0,0,0,0, 0,1,0);
    v(1,0,0,0,0,0, 1,1,1);
    v(1,0,0,0,0,1, 1,0,0);
    // reset mid-run, then load 0
    v(1,1,9,0,0,0, 9,1,0);
    v(1,0,0,0,0,0, 8,1,0);
    v(1,0,0,0,0,0, 7,1,0);
    v(1,0,0,0,0,0, 6,1,0);
    v(0,0,0,0,0,0, 0,0,0);
    v(1,1,0,0,0,0, 0,1,0);
    v(1,0,0,0,0,0, 0,0,1);
    v(1,0,0,0,0,0, 0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].lv, vecs[i].m, vecs[i].h, vecs[i].sp);
      step();
      chk("count", i, count, vecs[i].ec);
      chk("busy",  i, W'(busy), W'(vecs[i].eb));
      chk("done",  i, W'(done), W'(vecs[i].ed));
    end

    // full range: load 15, count down without wrap, done 16 edges after load
    drive(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_load", 0, count, 4'd15);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    n = 1;
    while (n <= 20) begin
      step();
      if (n <= 15) chk("full_count", n, count, W'(15 - n));
      if (done) break;
      n++;
    end
    chk("full_latency", 0, W'(n), W'(16));
    chk("full_busy_end", 0, W'(busy), W'(0));
    chk("full_count_end", 0, count, 4'd0);
    step();
    chk("full_done_once", 0, W'(done), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
